// File: rtl/spi_frame_pkg.sv
// Shared FSM state type and CRC-8 helper for the SPI control-frame receiver.
package spi_frame_pkg;

    typedef enum logic [2:0] {
        ARM   = 3'd0,
        IDLE  = 3'd1,
        RECV  = 3'd2,
        CHECK = 3'd3,
        HOLD  = 3'd4
    } state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // One byte of CRC-8, MSB first, no reflection.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Brings the asynchronous MCU SPI pins into the clk domain and derives the
// SCLK rising edge and the CS edges the frame receiver acts on.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_sclk,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic sclk_rise,
    output logic cs_fall,
    output logic cs_rise,
    output logic cs_s,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    // CS resets as "selected" so a frame already running at reset release never looks like an idle bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign cs_fall   = ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q;
    assign cs_rise   = cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;

endmodule

// File: rtl/spi_frame_rx.sv
// Oversampling SPI control-frame receiver: length check, frame publish and the
// time-update / WCW-reset / write strobe sequence. Define SPI_FRAME_CRC_EN to add a trailing CRC-8 byte.
module spi_frame_rx
    import spi_frame_pkg::*;
#(
    parameter int N_BYTES     = 51,
    parameter int TIME_BYTES  = 8,
    parameter int DELAY_WR    = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    spi_sclk,
    input  logic                    spi_cs_n,
    input  logic                    spi_mosi,
    output logic [8*N_BYTES-1:0]    frame_data,
    output logic [8*TIME_BYTES-1:0] time_preset,
    output logic                    frame_wr,
    output logic                    sys_time_update,
    output logic                    reset_wcw,
    output logic                    frame_err,
    output logic [15:0]             err_cnt,
    output logic                    busy,
    output state_e                  state_dbg
);

`ifdef SPI_FRAME_CRC_EN
    localparam int RX_BYTES = N_BYTES + 1;
`else
    localparam int RX_BYTES = N_BYTES;
`endif
    localparam int SR_W = 8 * RX_BYTES;
    localparam int FD_W = 8 * N_BYTES;
    localparam int TP_W = 8 * TIME_BYTES;
    localparam int BC_W = $clog2(RX_BYTES + 2);
    localparam int TM_W = $clog2(DELAY_WR);

    localparam logic [BC_W-1:0] BC_FULL = BC_W'(RX_BYTES);
    localparam logic [BC_W-1:0] BC_OVF  = BC_W'(RX_BYTES + 1);
    localparam logic [TM_W-1:0] TM_LOAD = TM_W'(DELAY_WR - 1);
    localparam logic [TM_W-1:0] TM_ONE  = TM_W'(1);

    logic sclk_rise;
    logic cs_fall;
    logic cs_rise;
    logic cs_s;
    logic mosi_s;

    spi_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .spi_sclk (spi_sclk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .sclk_rise(sclk_rise),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .cs_s     (cs_s),
        .mosi_s   (mosi_s)
    );

    state_e            state_q, state_d;
    logic [SR_W-1:0]   shift_q, shift_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [FD_W-1:0]   frame_q, frame_d;
    logic [TM_W-1:0]   timer_q, timer_d;
    logic              stu_q, stu_d;
    logic              rwcw_q, rwcw_d;
    logic              wr_q, wr_d;
    logic              ferr_q, ferr_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic              reject_q, reject_d;
    logic              err_inc;
    logic              crc_ok;
    logic              frame_ok;
    logic [FD_W-1:0]   payload;
    logic [TP_W-1:0]   time_field;

`ifdef SPI_FRAME_CRC_EN
    logic [7:0] crc_q, crc_d;
    // Running the CRC over payload plus its own CRC byte leaves a zero residue on a clean frame.
    assign crc_ok = (crc_q == 8'h00);
`else
    assign crc_ok = 1'b1;
`endif

    assign payload    = shift_q[SR_W-1 -: FD_W];
    assign time_field = payload[FD_W-1 -: TP_W];
    assign frame_ok   = (byte_cnt_q == BC_FULL) && (bit_cnt_q == 3'd0) && crc_ok;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        frame_d    = frame_q;
        timer_d    = timer_q;
        stu_d      = 1'b0;
        rwcw_d     = 1'b0;
        wr_d       = 1'b0;
        err_cnt_d  = err_cnt_q;
        reject_d   = reject_q;
        err_inc    = 1'b0;
`ifdef SPI_FRAME_CRC_EN
        crc_d      = crc_q;
`endif

        // A frame that started during HOLD is rejected once its CS release arrives.
        if (reject_q && cs_rise) begin
            err_inc  = 1'b1;
            reject_d = 1'b0;
        end

        case (state_q)
            ARM: begin
                if (cs_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (cs_fall) begin
                    state_d    = RECV;
                    shift_d    = '0;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = '0;
`ifdef SPI_FRAME_CRC_EN
                    crc_d      = 8'h00;
`endif
                end
            end
            RECV: begin
                if (cs_rise) begin
                    state_d = CHECK;
                end else if (sclk_rise) begin
                    shift_d   = {shift_q[SR_W-2:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (byte_cnt_q != BC_OVF) begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
`ifdef SPI_FRAME_CRC_EN
                        crc_d = crc8_byte(crc_q, {shift_q[6:0], mosi_s});
`endif
                    end
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (frame_ok) begin
                    frame_d = payload;
                    if (time_field == '0) begin
                        wr_d = 1'b1;
                    end else begin
                        state_d = HOLD;
                        timer_d = TM_LOAD;
                        stu_d   = 1'b1;
                        rwcw_d  = 1'b1;
                    end
                end else begin
                    err_inc = 1'b1;
                end
            end
            HOLD: begin
                if (cs_fall) begin
                    reject_d = 1'b1;
                end
                // timer_q counts the remaining high cycles of sys_time_update after this one.
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                    stu_d   = 1'b1;
                    rwcw_d  = (timer_q == TM_LOAD);
                    wr_d    = (timer_q == TM_ONE);
                end
            end
            default: begin
                state_d = ARM;
            end
        endcase

        ferr_d = err_inc;
        if (err_inc && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARM;
            shift_q    <= '0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= '0;
            frame_q    <= '0;
            timer_q    <= '0;
            stu_q      <= 1'b0;
            rwcw_q     <= 1'b0;
            wr_q       <= 1'b0;
            ferr_q     <= 1'b0;
            err_cnt_q  <= 16'd0;
            reject_q   <= 1'b0;
`ifdef SPI_FRAME_CRC_EN
            crc_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            frame_q    <= frame_d;
            timer_q    <= timer_d;
            stu_q      <= stu_d;
            rwcw_q     <= rwcw_d;
            wr_q       <= wr_d;
            ferr_q     <= ferr_d;
            err_cnt_q  <= err_cnt_d;
            reject_q   <= reject_d;
`ifdef SPI_FRAME_CRC_EN
            crc_q      <= crc_d;
`endif
        end
    end

    assign frame_data      = frame_q;
    assign time_preset     = frame_q[FD_W-1 -: TP_W];
    assign frame_wr        = wr_q;
    assign sys_time_update = stu_q;
    assign reset_wcw       = rwcw_q;
    assign frame_err       = ferr_q;
    assign err_cnt         = err_cnt_q;
    assign busy            = (state_q == RECV) || (state_q == HOLD);
    assign state_dbg       = state_q;

endmodule
